// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM encoding and the prediction-queue entry layout.
package bru_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } state_t;

  localparam int unsigned ADDR_W_DFLT = 32;

  // Canonical entry layout, MSB first: {taken, target, fallthru}.
  typedef struct packed {
    logic                   taken;
    logic [ADDR_W_DFLT-1:0] target;
    logic [ADDR_W_DFLT-1:0] fallthru;
  } entry_t;

  localparam int unsigned ENTRY_W = $bits(entry_t);

  function automatic int unsigned entry_width(input int unsigned addr_w);
    return 2 * addr_w + 1;
  endfunction

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order queue of outstanding branch predictions; clear wins over push.
module bru_pred_fifo #(
  parameter int unsigned WIDTH = 65,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // A pop frees the head slot in the same cycle, so a full queue can still accept a push.
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks resolved branches against queued fetch predictions; flushes and redirects on mispredict.
// Define BRU_STATS_EN to build the resolved-branch and mispredict counters.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              pred_valid,
  input  logic              pred_taken,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic [ADDR_W-1:0] pred_fallthru,
  input  logic              res_valid,
  input  logic              res_equal,
  input  logic [ADDR_W-1:0] res_target,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic              err,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  mis_cnt
);

  localparam int unsigned EW = entry_width(ADDR_W);

  state_t            state_q;
  logic              flush_q;
  logic [ADDR_W-1:0] redirect_pc_q;
  logic              upd_valid_q;
  logic              upd_taken_q;
  logic              err_q;

  logic              idle;
  logic              push_req;
  logic              pop_req;
  logic              pop_ok;
  logic              push_ok;
  logic              mispredict;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     wr_entry;
  logic [EW-1:0]     head;
  logic              head_taken;
  logic [ADDR_W-1:0] head_target;
  logic [ADDR_W-1:0] head_fallthru;

  assign idle     = (state_q == IDLE);
  assign push_req = pred_valid & ~stall & idle;
  assign pop_req  = res_valid & idle;
  assign pop_ok   = pop_req & ~fifo_empty;
  assign push_ok  = push_req & (~fifo_full | pop_ok);

  assign wr_entry      = {pred_taken, pred_target, pred_fallthru};
  assign head_taken    = head[EW-1];
  assign head_target   = head[2*ADDR_W-1:ADDR_W];
  assign head_fallthru = head[ADDR_W-1:0];

  assign mispredict = pop_ok & ((head_taken != res_equal) |
                                (res_equal & head_taken & (head_target != res_target)));

  // Everything still queued behind a mispredicted branch is on the wrong path.
  bru_pred_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .pop_i   (pop_ok),
    .clear_i (mispredict),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_valid_q   <= 1'b0;
      upd_taken_q   <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      upd_valid_q   <= pop_ok;
      upd_taken_q   <= pop_ok & res_equal;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      if ((pop_req & fifo_empty) | (push_req & fifo_full & ~pop_ok)) begin
        err_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (mispredict) begin
            state_q       <= REDIRECT;
            flush_q       <= 1'b1;
            redirect_pc_q <= res_equal ? res_target : head_fallthru;
          end
        end
        REDIRECT: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_pc_q;
  assign upd_valid   = upd_valid_q;
  assign upd_taken   = upd_taken_q;
  assign err         = err_q;

`ifdef BRU_STATS_EN
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (pop_ok && (br_cnt_q != '1))      br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (mispredict && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign br_cnt  = br_cnt_q;
  assign mis_cnt = mis_cnt_q;
`else
  assign br_cnt  = '0;
  assign mis_cnt = '0;
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolves branches in the resolve stage against the prediction made at fetch by the 2-bit predictor.
- Tracks in-flight predictions in a small in-order queue.
- On a mispredict, raises a one-cycle flush with the corrected PC and feeds the actual outcome back to the predictor as its update (branch / equal_or_not).
- Sits between the fetch-stage predictor and the EX-stage comparator of the pipelined MIPS core.

Parameters:
- ADDR_W, 32, PC width.
- DEPTH, 2, maximum number of in-flight predicted branches (power of 2, ≥2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  pipeline stall; blocks push.
- pred_valid  in  1  fetch issued a branch with a prediction.
- pred_taken  in  1  predictor output (branch_or_not).
- pred_target  in  ADDR_W  predicted-taken target.
- pred_fallthru  in  ADDR_W  PC+4 of the branch.
- res_valid  in  1  branch resolved in EX this cycle.
- res_equal  in  1  actual outcome; 1 = taken.
- res_target  in  ADDR_W  computed actual target.
- flush  out  1  squash younger instructions.
- redirect_pc  out  ADDR_W  corrected fetch PC; valid when flush=1.
- upd_valid  out  1  predictor update strobe (drives predictor branch).
- upd_taken  out  1  actual outcome (drives predictor equal_or_not).
- err  out  1  sticky protocol error.
- br_cnt  out  CNT_W  resolved branches.
- mis_cnt  out  CNT_W  mispredicts.

Behaviour:
- Reset values: all outputs 0, queue empty, FSM = IDLE. Reset mid-flush aborts the flush on the next edge.
- Push: pred_valid & ~stall & (state==IDLE) writes {pred_taken, pred_target, pred_fallthru} at the tail.
- Pop: res_valid & (state==IDLE) reads the head.
- Simultaneous push and pop is legal at any occupancy, including full.
- Mispredict when (head.taken != res_equal) or (res_equal & head.taken & head.target != res_target).
- Latency: all outputs registered, asserted exactly 1 cycle after the resolving res_valid.
  - upd_valid=1 and upd_taken=res_equal for every pop, correct or not.
- FSM has two states, IDLE and REDIRECT:
  - IDLE→REDIRECT on a pop that mispredicts; flush=1 for that one cycle.
  - redirect_pc = res_equal ? res_target : head.fallthru.
  - REDIRECT→IDLE unconditionally after one cycle.
  - Queue is cleared on the IDLE→REDIRECT edge; a same-cycle push is discarded (it is younger).
  - In REDIRECT, pred_valid and res_valid are ignored (squashed ops).
- Boundary conditions:
  - Pop with queue empty: no update, no flush, err set.
  - Push when full without a simultaneous pop: entry dropped, err set.
  - err clears only on rst.
- Counters: br_cnt +1 per accepted pop, mis_cnt +1 per mispredict. Both saturate at all-ones, no wrap.
- Pointer arithmetic is modulo DEPTH, with occupancy count width clog2(DEPTH)+1.

Optional Feature:
- Macro BRU_STATS_EN.
- Defined: br_cnt and mis_cnt are implemented as above.
- Undefined: counter registers are not built and both ports are tied to 0. All other behaviour is identical.

Decomposition:
- Shared package bru_pkg holds:
  - FSM encoding (IDLE=1'b0, REDIRECT=1'b1).
  - Queue entry struct {taken, target, fallthru}.
  - Entry width constant.
- One sub-module, bru_pred_fifo: synchronous DEPTH-entry FIFO with push, pop, clear, full and empty. Clear has priority over push.

Test Plan:
- Correct not-taken: push taken=0, fallthru=0x104; 2 cycles later res_valid, equal=0 → upd_valid=1, upd_taken=0, flush=0, br_cnt=1, mis_cnt=0.
- Taken mispredict: push taken=0, fallthru=0x204; res equal=1, target=0x300 → next cycle flush=1 and redirect_pc=0x300 for exactly 1 cycle; mis_cnt=1; queue empty afterwards.
- Wrong target: push taken=1, target=0x400; res equal=1, target=0x480 → flush=1, redirect_pc=0x480.
- Squash: two pushes (A, B), with A mispredicted and a push C in the same cycle → flush; B and C discarded. A later res_valid in IDLE with the queue empty sets err=1.
- Full and stall: DEPTH=2, push 2 entries, then a third push with no pop → err=1 and entry dropped. pred_valid with stall=1 is never queued.
- Reset and saturation: rst during REDIRECT → next cycle flush=0, queue empty, err=0. With CNT_W=4, 17 mispredicts → mis_cnt holds 15.
